pipe_ctrl: RTL and testbench

Central pipeline controller for the five-stage core. It merges stall requests from ID, EX and MEM into the per-stage `stall` vector that freezes the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It sequences exception and ERET flushes, supplying the redirect PC. An optional watchdog flags runaway stalls.

---
 rtl/pipe_ctrl.sv | 109 ++++++++++
 tb/tb_pipe_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: five-stage pipeline stall/flush controller with optional stall watchdog
//
// Ports:
//   clk               rising-edge clock
//   rst               synchronous reset, active low
//   stallreq_from_id  ID stage stall request
//   stallreq_from_ex  EX stage stall request
//   stallreq_from_mem MEM stage stall request
//   except_valid_i    MEM commits an exception this cycle
//   except_eret_i     committing event is ERET (qualified by except_valid_i)
//   epc_i             EPC from CP0, sampled with except_valid_i
//   stall[5:0]        freeze vector: PC, IF/ID, ID/EX, EX/MEM, MEM/WB, WB
//   flush             clear all pipeline registers
//   new_pc            redirect target, valid while flush is high
//   stall_timeout_o   sticky runaway-stall flag
//
// Optional feature: define PIPE_CTRL_WATCHDOG_EN to build the stall watchdog.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          STALL_LIMIT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic        except_valid_i,
    input  logic        except_eret_i,
    input  logic [31:0] epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout_o
);
    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t     r_state;
    logic [3:0] r_fcnt;
    logic       w_any;

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || STALL_LIMIT < 1 || STALL_LIMIT > 255) begin : g_bad_param
        $error("pipe_ctrl: FLUSH_CYCLES or STALL_LIMIT out of range");
    end

    assign w_any = stallreq_from_id | stallreq_from_ex | stallreq_from_mem;

    // Deeper requesters freeze every stage upstream of themselves.
    always_comb
        stall = (!rst || r_state == FLUSH) ? 6'b000000 :
                stallreq_from_mem          ? 6'b011111 :
                stallreq_from_ex           ? 6'b001111 :
                stallreq_from_id           ? 6'b000111 : 6'b000000;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= RUN;
            r_fcnt  <= 4'd0;
            flush   <= 1'b0;
            new_pc  <= 32'h0;
        end else begin
            case (r_state)
                FLUSH: begin
                    // Events arriving here are dropped, not queued.
                    if (r_fcnt == 4'(FLUSH_CYCLES - 1)) begin
                        r_state <= RUN;
                        flush   <= 1'b0;
                    end else begin
                        r_fcnt <= r_fcnt + 4'd1;
                    end
                end
                default: begin
                    if (except_valid_i) begin
                        r_state <= FLUSH;
                        r_fcnt  <= 4'd0;
                        flush   <= 1'b1;
                        new_pc  <= except_eret_i ? epc_i : EXC_VECTOR;
                    end else begin
                        r_state <= w_any ? STALL : RUN;
                    end
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_WATCHDOG_EN
    logic [7:0] r_scnt;
    logic [7:0] w_scnt_nx;
    logic       r_timeout;

    // Counts consecutive cycles with the pipeline frozen; saturates at 255.
    assign w_scnt_nx = (stall == 6'd0) ? 8'd0 : (r_scnt == 8'hFF) ? r_scnt : r_scnt + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_scnt    <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_scnt <= w_scnt_nx;
            if (w_scnt_nx == 8'(STALL_LIMIT))
                r_timeout <= 1'b1;
        end
    end

    assign stall_timeout_o = r_timeout;
`else
    assign stall_timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table-driven self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id = 1'b0, ex = 1'b0, mem = 1'b0, exv = 1'b0, eret = 1'b0;
    logic [31:0] epc = 32'h0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        tout;

`ifdef PIPE_CTRL_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    always #5 clk = ~clk;

    pipe_ctrl #(.EXC_VECTOR(32'h0000_0020), .FLUSH_CYCLES(3), .STALL_LIMIT(4)) dut (
        .clk(clk),
        .rst(rst),
        .stallreq_from_id(id),
        .stallreq_from_ex(ex),
        .stallreq_from_mem(mem),
        .except_valid_i(exv),
        .except_eret_i(eret),
        .epc_i(epc),
        .stall(stall),
        .flush(flush),
        .new_pc(new_pc),
        .stall_timeout_o(tout)
    );

    typedef struct {
        logic        r, i, e, m, x, t;
        logic [31:0] pc_in;
        logic [5:0]  s;
        logic        f;
        logic [31:0] np;
        logic        to;
    } vec_t;

    vec_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r, i, e, m, x, t, input logic [31:0] pc_in,
                       input logic [5:0] s, input logic f, input logic [31:0] np, input logic to);
        vec_t v;
        v.r = r; v.i = i; v.e = e; v.m = m; v.x = x; v.t = t; v.pc_in = pc_in;
        v.s = s; v.f = f; v.np = np; v.to = to;
        q.push_back(v);
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", n, act, req);
        end
    endtask

    initial begin
        int n;
        //   r  i  e  m  x  t  epc           stall  f  new_pc        to
        add(0, 1, 1, 1, 1, 0, 32'h0,        6'h00, 0, 32'h0,        0);
        add(0, 1, 1, 1, 1, 0, 32'h0,        6'h00, 0, 32'h0,        0);
        add(0, 1, 1, 1, 1, 0, 32'h0,        6'h00, 0, 32'h0,        0);
        add(1, 1, 0, 0, 0, 0, 32'h0,        6'h07, 0, 32'h0,        0);
        add(1, 1, 1, 0, 0, 0, 32'h0,        6'h0F, 0, 32'h0,        0);
        add(1, 1, 1, 1, 0, 0, 32'h0,        6'h1F, 0, 32'h0,        0);
        add(1, 0, 0, 0, 0, 0, 32'h0,        6'h00, 0, 32'h0,        0);
        add(1, 0, 0, 0, 0, 0, 32'h0,        6'h00, 0, 32'h0,        0);
        add(1, 0, 1, 0, 0, 0, 32'h0,        6'h0F, 0, 32'h0,        0);
        add(1, 0, 1, 0, 1, 0, 32'h0,        6'h0F, 0, 32'h0,        0);
        add(1, 0, 1, 0, 0, 0, 32'h0,        6'h00, 1, 32'h20,       0);
        add(1, 0, 1, 0, 0, 0, 32'h0,        6'h00, 1, 32'h20,       0);
        add(1, 0, 1, 0, 0, 0, 32'h0,        6'h00, 1, 32'h20,       0);
        add(1, 0, 1, 0, 0, 0, 32'h0,        6'h0F, 0, 32'h20,       0);
        add(1, 0, 0, 0, 0, 0, 32'h0,        6'h00, 0, 32'h20,       0);
        add(1, 0, 0, 0, 1, 1, 32'h1234,     6'h00, 0, 32'h20,       0);
        add(1, 0, 0, 0, 1, 0, 32'h0,        6'h00, 1, 32'h1234,     0);
        add(1, 0, 0, 0, 1, 0, 32'h0,        6'h00, 1, 32'h1234,     0);
        add(1, 0, 0, 0, 0, 0, 32'h0,        6'h00, 1, 32'h1234,     0);
        add(1, 0, 0, 0, 1, 0, 32'h0,        6'h00, 0, 32'h1234,     0);
        add(1, 0, 0, 0, 0, 0, 32'h0,        6'h00, 1, 32'h20,       0);
        add(0, 0, 0, 1, 0, 0, 32'h0,        6'h00, 1, 32'h20,       0);
        add(1, 0, 0, 0, 0, 0, 32'h0,        6'h00, 0, 32'h0,        0);
        add(1, 1, 0, 0, 0, 0, 32'h0,        6'h07, 0, 32'h0,        0);
        add(1, 0, 0, 0, 0, 0, 32'h0,        6'h00, 0, 32'h0,        0);
        for (int k = 0; k < 3; k++) add(1, 0, 1, 0, 0, 0, 32'h0, 6'h0F, 0, 32'h0, 0);
        add(1, 0, 0, 0, 0, 0, 32'h0,        6'h00, 0, 32'h0,        0);
        for (int k = 0; k < 3; k++) add(1, 1, 0, 0, 0, 0, 32'h0, 6'h07, 0, 32'h0, 0);
        add(1, 0, 0, 0, 0, 0, 32'h0,        6'h00, 0, 32'h0,        0);
        for (int k = 0; k < 4; k++) add(1, 0, 0, 1, 0, 0, 32'h0, 6'h1F, 0, 32'h0, 0);
        add(1, 0, 0, 0, 0, 0, 32'h0,        6'h00, 0, 32'h0,        1);
        add(1, 0, 0, 0, 0, 0, 32'h0,        6'h00, 0, 32'h0,        1);

        rst = 1'b0; id = 1'b1; ex = 1'b1; mem = 1'b1; exv = 1'b1;
        @(posedge clk);
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            rst = q[k].r; id = q[k].i; ex = q[k].e; mem = q[k].m;
            exv = q[k].x; eret = q[k].t; epc = q[k].pc_in;
            #1;
            chk($sformatf("row%0d stall", k), 32'(stall), 32'(q[k].s));
            chk($sformatf("row%0d flush", k), 32'(flush), 32'(q[k].f));
            chk($sformatf("row%0d new_pc", k), new_pc, q[k].np);
            chk($sformatf("row%0d timeout", k), 32'(tout), 32'(WD & q[k].to));
        end

        // Flush length measured directly, then a request right after flush ends.
        @(negedge clk);
        exv = 1'b1; eret = 1'b0;
        @(negedge clk);
        exv = 1'b0;
        #1;
        n = 0;
        while (flush === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("flush_len", 32'(n), 32'd3);
        ex = 1'b1;
        #1;
        chk("post_flush_stall", 32'(stall), 32'h0F);
        chk("timeout_sticky", 32'(tout), 32'(WD));
        ex = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
